// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
// Optional halt-marker detection is enabled with the macro FETCH_HALT_DETECT_EN.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DONE  = 2'd2
    } fetch_state_t;

    localparam logic [31:0] PC_STEP   = 32'd4;
    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO holding {PC, instruction} pairs for the decode stage.
// Flush has priority over push and pop; head data reads as zero while empty.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic         i_flush,
    input  fetch_entry_t i_data,
    output logic         o_full,
    output logic         o_empty,
    output fetch_entry_t o_head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    fetch_entry_t     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wrPtr;
    logic [PTR_W-1:0] r_rdPtr;
    logic [CNT_W-1:0] r_count;
    logic             w_doPush;
    logic             w_doPop;

    assign o_empty  = (r_count == '0);
    assign o_full   = (r_count == CNT_W'(DEPTH));
    assign w_doPop  = i_pop && !o_empty;
    assign w_doPush = i_push && (!o_full || w_doPop);
    assign o_head   = o_empty ? '0 : r_mem[r_rdPtr];

    // Pointer and occupancy bookkeeping; a flush empties the queue outright.
    always_ff @(posedge i_clk) begin
        if (i_reset || i_flush) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= r_wrPtr + PTR_W'(1);
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + PTR_W'(1);
            end
            if (w_doPush && !w_doPop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_doPop && !w_doPush) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    // Entry storage; contents are only observed through the gated head.
    always_ff @(posedge i_clk) begin
        if (w_doPush && !i_flush && !i_reset) begin
            r_mem[r_wrPtr] <= i_data;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch controller: owns the PC, reads the combinational instruction memory
// and queues {PC, instruction} pairs for decode, honouring redirects.
// Optional macro FETCH_HALT_DETECT_EN turns the word 32'hFFFF_FFFF into a halt marker.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int          IMEM_WORDS  = 128,
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          QUEUE_DEPTH = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    output logic [31:0] ImemAddress,
    input  logic [31:0] ImemInstruction,
    input  logic        RedirectValid,
    input  logic [31:0] RedirectPC,
    output logic        OutValid,
    input  logic        OutReady,
    output logic [31:0] OutInstruction,
    output logic [31:0] OutPC,
    output logic        Halted
);

    localparam logic [31:0] PC_LIMIT = 32'(IMEM_WORDS) * PC_STEP;

    fetch_state_t r_state;
    fetch_state_t w_stateNext;
    logic [31:0]  r_pc;
    logic [31:0]  w_pcNext;
    logic [31:0]  w_pcPlus;
    logic [31:0]  w_redirTarget;
    logic         r_halted;
    logic         w_push;
    logic         w_pop;
    logic         w_flush;
    logic         w_space;
    logic         w_full;
    logic         w_empty;
    logic         w_haltMarker;
    fetch_entry_t w_pushData;
    fetch_entry_t w_head;

`ifdef FETCH_HALT_DETECT_EN
    assign w_haltMarker = (ImemInstruction == HALT_WORD);
`else
    assign w_haltMarker = 1'b0;
`endif

    assign OutValid         = !w_empty;
    assign OutInstruction   = w_head.instr;
    assign OutPC            = w_head.pc;
    assign ImemAddress      = r_pc;
    assign Halted           = r_halted;
    assign w_pop            = OutValid && OutReady;
    assign w_space          = !w_full || w_pop;
    assign w_pcPlus         = r_pc + PC_STEP;
    assign w_redirTarget    = RedirectPC & ~32'd3;
    assign w_pushData.pc    = r_pc;
    assign w_pushData.instr = ImemInstruction;

    // Next-state, next-PC and queue control; a redirect outranks everything once fetching.
    always_comb begin
        w_stateNext = r_state;
        w_pcNext    = r_pc;
        w_push      = 1'b0;
        w_flush     = 1'b0;
        if (RedirectValid && (r_state != IDLE)) begin
            w_flush     = 1'b1;
            w_pcNext    = w_redirTarget;
            w_stateNext = (w_redirTarget >= PC_LIMIT) ? DONE : FETCH;
        end else begin
            case (r_state)
                IDLE: begin
                    if (Start) begin
                        w_stateNext = FETCH;
                    end
                end
                FETCH: begin
                    if (w_space) begin
                        if (w_haltMarker) begin
                            w_stateNext = DONE;
                        end else begin
                            w_push   = 1'b1;
                            w_pcNext = w_pcPlus;
                            if (w_pcPlus >= PC_LIMIT) begin
                                w_stateNext = DONE;
                            end
                        end
                    end
                end
                DONE: begin
                    w_stateNext = DONE;
                end
                default: begin
                    w_stateNext = IDLE;
                end
            endcase
        end
    end

    // State, PC and halt-status registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state  <= IDLE;
            r_pc     <= RESET_PC;
            r_halted <= 1'b0;
        end else begin
            r_state  <= w_stateNext;
            r_pc     <= w_pcNext;
            r_halted <= !w_flush && (r_state == DONE) && w_empty;
        end
    end

    fetch_queue #(
        .DEPTH (QUEUE_DEPTH)
    ) uQueue (
        .i_clk   (Clk),
        .i_reset (Reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .i_data  (w_pushData),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (w_head)
    );

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed testbench for fetch_sequencer with a behavioural 128-word memory.
// Build with FETCH_HALT_DETECT_EN defined to exercise the halt-marker variant.
module tb_fetch_sequencer;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Start;
    logic [31:0] ImemAddress;
    logic [31:0] ImemInstruction;
    logic        RedirectValid;
    logic [31:0] RedirectPC;
    logic        OutValid;
    logic        OutReady;
    logic [31:0] OutInstruction;
    logic [31:0] OutPC;
    logic        Halted;

    logic [31:0] imem [128];
    int          checks = 0;
    int          errors = 0;

    fetch_sequencer dut (
        .Clk             (Clk),
        .Reset           (Reset),
        .Start           (Start),
        .ImemAddress     (ImemAddress),
        .ImemInstruction (ImemInstruction),
        .RedirectValid   (RedirectValid),
        .RedirectPC      (RedirectPC),
        .OutValid        (OutValid),
        .OutReady        (OutReady),
        .OutInstruction  (OutInstruction),
        .OutPC           (OutPC),
        .Halted          (Halted)
    );

    // Free-running clock, 10 time units per period.
    always #5 Clk = ~Clk;

    // Combinational instruction memory; out-of-range addresses read zero.
    assign ImemInstruction = (ImemAddress < 32'd512) ? imem[ImemAddress[8:2]] : 32'h0;

    task automatic cycle();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Reset         = 1'b1;
        Start         = 1'b0;
        RedirectValid = 1'b0;
        RedirectPC    = 32'h0;
        OutReady      = 1'b0;
        cycle();
        Reset = 1'b0;
    endtask

    task automatic pulse_start();
        Start = 1'b1;
        cycle();
        Start = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks += 5;
        if (OutValid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", OutValid); end
        if (OutPC !== 32'h0) begin errors++; $display("[TB] FAIL reset_pc: got %h expected 0", OutPC); end
        if (OutInstruction !== 32'h0) begin errors++; $display("[TB] FAIL reset_instr: got %h expected 0", OutInstruction); end
        if (Halted !== 1'b0) begin errors++; $display("[TB] FAIL reset_halted: got %b expected 0", Halted); end
        if (ImemAddress !== 32'h0) begin errors++; $display("[TB] FAIL reset_addr: got %h expected 0", ImemAddress); end
    endtask

    task automatic test_stream();
        int n;
        do_reset();
        OutReady = 1'b1;
        pulse_start();
        checks++;
        if (OutValid !== 1'b0) begin errors++; $display("[TB] FAIL stream_first_latency: got valid %b expected 0", OutValid); end
        cycle();
        for (int k = 0; k < 128; k++) begin
            checks++;
            if (OutValid !== 1'b1 || OutPC !== 32'(k * 4) || OutInstruction !== 32'(k * 3)) begin
                errors++;
                $display("[TB] FAIL stream_word%0d: got v=%b pc=%h ins=%h expected v=1 pc=%h ins=%h",
                         k, OutValid, OutPC, OutInstruction, 32'(k * 4), 32'(k * 3));
            end
            cycle();
        end
        n = 0;
        while (Halted !== 1'b1 && n < 10) begin
            cycle();
            n++;
        end
        checks += 2;
        if (Halted !== 1'b1) begin errors++; $display("[TB] FAIL stream_halted: got %b expected 1", Halted); end
        if (OutValid !== 1'b0) begin errors++; $display("[TB] FAIL stream_drained: got %b expected 0", OutValid); end
    endtask

    task automatic test_backpressure();
        do_reset();
        OutReady = 1'b0;
        pulse_start();
        for (int i = 0; i < 4; i++) cycle();
        checks += 3;
        if (ImemAddress !== 32'h8) begin errors++; $display("[TB] FAIL bp_addr_hold: got %h expected 8", ImemAddress); end
        if (OutValid !== 1'b1 || OutPC !== 32'h0) begin errors++; $display("[TB] FAIL bp_head_stable: got v=%b pc=%h expected v=1 pc=0", OutValid, OutPC); end
        if (OutInstruction !== 32'h0) begin errors++; $display("[TB] FAIL bp_head_instr: got %h expected 0", OutInstruction); end
        OutReady = 1'b1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (OutValid !== 1'b1 || OutPC !== 32'(k * 4) || OutInstruction !== 32'(k * 3)) begin
                errors++;
                $display("[TB] FAIL bp_accept%0d: got pc=%h ins=%h expected pc=%h ins=%h",
                         k, OutPC, OutInstruction, 32'(k * 4), 32'(k * 3));
            end
            cycle();
        end
    endtask

    task automatic test_redirect_full();
        do_reset();
        OutReady = 1'b0;
        pulse_start();
        for (int i = 0; i < 3; i++) cycle();
        OutReady      = 1'b1;
        RedirectValid = 1'b1;
        RedirectPC    = 32'h0000_0042;
        cycle();
        RedirectValid = 1'b0;
        checks += 2;
        if (OutValid !== 1'b0) begin errors++; $display("[TB] FAIL redir_flush: got valid %b expected 0", OutValid); end
        if (ImemAddress !== 32'h40) begin errors++; $display("[TB] FAIL redir_addr: got %h expected 40", ImemAddress); end
        cycle();
        checks += 2;
        if (OutPC !== 32'h40 || OutInstruction !== 32'd48) begin errors++; $display("[TB] FAIL redir_first: got pc=%h ins=%h expected pc=40 ins=30", OutPC, OutInstruction); end
        cycle();
        if (OutPC !== 32'h44 || OutInstruction !== 32'd51) begin errors++; $display("[TB] FAIL redir_second: got pc=%h ins=%h expected pc=44 ins=33", OutPC, OutInstruction); end
    endtask

    task automatic test_redirect_done();
        int n;
        RedirectValid = 1'b1;
        RedirectPC    = 32'h0000_0400;
        cycle();
        RedirectValid = 1'b0;
        checks += 2;
        if (OutValid !== 1'b0) begin errors++; $display("[TB] FAIL done_flush: got %b expected 0", OutValid); end
        if (ImemAddress !== 32'h400) begin errors++; $display("[TB] FAIL done_addr: got %h expected 400", ImemAddress); end
        n = 0;
        while (Halted !== 1'b1 && n < 10) begin
            cycle();
            n++;
        end
        checks++;
        if (Halted !== 1'b1) begin errors++; $display("[TB] FAIL done_halted: got %b expected 1", Halted); end
        RedirectValid = 1'b1;
        RedirectPC    = 32'h0000_0010;
        cycle();
        RedirectValid = 1'b0;
        checks++;
        if (Halted !== 1'b0) begin errors++; $display("[TB] FAIL resume_halt_clear: got %b expected 0", Halted); end
        cycle();
        checks++;
        if (OutValid !== 1'b1 || OutPC !== 32'h10 || OutInstruction !== 32'd12) begin
            errors++;
            $display("[TB] FAIL resume_word: got v=%b pc=%h ins=%h expected v=1 pc=10 ins=c", OutValid, OutPC, OutInstruction);
        end
    endtask

    task automatic test_idle_redirect();
        do_reset();
        RedirectValid = 1'b1;
        RedirectPC    = 32'h80;
        cycle();
        checks++;
        if (ImemAddress !== 32'h0 || OutValid !== 1'b0) begin errors++; $display("[TB] FAIL idle_redirect_ignored: got addr=%h v=%b expected addr=0 v=0", ImemAddress, OutValid); end
        Start = 1'b1;
        cycle();
        Start         = 1'b0;
        RedirectValid = 1'b0;
        checks++;
        if (ImemAddress !== 32'h0) begin errors++; $display("[TB] FAIL start_wins_addr: got %h expected 0", ImemAddress); end
        cycle();
        checks++;
        if (OutValid !== 1'b1 || OutPC !== 32'h0) begin errors++; $display("[TB] FAIL start_wins_first: got v=%b pc=%h expected v=1 pc=0", OutValid, OutPC); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        pulse_start();
        for (int i = 0; i < 3; i++) cycle();
        Reset         = 1'b1;
        Start         = 1'b1;
        RedirectValid = 1'b1;
        RedirectPC    = 32'h20;
        cycle();
        Reset         = 1'b0;
        Start         = 1'b0;
        RedirectValid = 1'b0;
        OutReady      = 1'b1;
        checks += 2;
        if (OutValid !== 1'b0) begin errors++; $display("[TB] FAIL midreset_valid: got %b expected 0", OutValid); end
        if (ImemAddress !== 32'h0) begin errors++; $display("[TB] FAIL midreset_addr: got %h expected 0", ImemAddress); end
        for (int i = 0; i < 3; i++) cycle();
        checks++;
        if (OutValid !== 1'b0 || ImemAddress !== 32'h0) begin errors++; $display("[TB] FAIL midreset_idle: got v=%b addr=%h expected v=0 addr=0", OutValid, ImemAddress); end
        pulse_start();
        cycle();
        checks++;
        if (OutValid !== 1'b1 || OutPC !== 32'h0) begin errors++; $display("[TB] FAIL midreset_resume: got v=%b pc=%h expected v=1 pc=0", OutValid, OutPC); end
    endtask

    task automatic test_halt_marker();
        logic [31:0] lastPc;
        logic        sawMarker;
        int          n;
        imem[10] = 32'hFFFF_FFFF;
        do_reset();
        OutReady = 1'b1;
        pulse_start();
        lastPc    = 32'hDEAD_BEEF;
        sawMarker = 1'b0;
        n = 0;
        while (Halted !== 1'b1 && n < 200) begin
            if (OutValid === 1'b1) begin
                lastPc = OutPC;
                if (OutPC === 32'd40 && OutInstruction === 32'hFFFF_FFFF) sawMarker = 1'b1;
            end
            cycle();
            n++;
        end
        checks += 2;
`ifdef FETCH_HALT_DETECT_EN
        if (lastPc !== 32'd36) begin errors++; $display("[TB] FAIL marker_last_pc: got %h expected 24", lastPc); end
        if (Halted !== 1'b1) begin errors++; $display("[TB] FAIL marker_halted: got %b expected 1", Halted); end
`else
        if (sawMarker !== 1'b1) begin errors++; $display("[TB] FAIL marker_delivered: got %b expected 1", sawMarker); end
        if (lastPc !== 32'd508) begin errors++; $display("[TB] FAIL marker_full_run: got %h expected 1fc", lastPc); end
`endif
        imem[10] = 32'd30;
    endtask

    // Test sequence: fill memory, run each scenario, report.
    initial begin
        for (int i = 0; i < 128; i++) imem[i] = 32'(i * 3);
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_full();
        test_redirect_done();
        test_idle_redirect();
        test_reset_mid();
        test_halt_marker();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
